t_bank_arbiter: RTL

- Round-robin arbiter and sequencer that shares one WIDTH-bit bank of T flip-flops (toggle register) between NREQ requesters.
- Each requester presents a toggle mask. The block grants one requester at a time, applies q <= q ^ mask, and acknowledges.
- Sits between the toggle-based state registers and the control agents that flip them, so that only one agent updates the bank per transaction.

---
 rtl/t_bank_pkg.sv | 25 ++
 rtl/t_bank_arbiter_rr_pick.sv | 33 +++
 rtl/t_bank_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/t_bank_pkg.sv
// Shared types and width helpers for the T flip-flop bank arbiter.
package t_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    APPLY = 2'd2,
    ACK   = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 30; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Pointer needs at least one bit even when a single requester exists.
  function automatic int ptrWidth(input int nreq);
    return (clog2(nreq) < 1) ? 1 : clog2(nreq);
  endfunction

endpackage

// File: rtl/t_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping around, reported both one-hot and as an index.
module rr_pick
  import t_bank_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_win,
  output logic [PTR_W-1:0] o_winIdx
);

  always_comb begin : pick
    logic found;
    int   idx;
    o_win    = '0;
    o_winIdx = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(i_ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && i_req[idx]) begin
        found      = 1'b1;
        o_win[idx] = 1'b1;
        o_winIdx   = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/t_bank_arbiter.sv
// Round-robin sequencer sharing one toggle register bank among NREQ agents.
// Optional registered parity output q_par enabled by T_BANK_PARITY_EN.
module t_bank_arbiter
  import t_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] tmask,
  input  logic                  clr,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic [WIDTH-1:0]      q,
`ifdef T_BANK_PARITY_EN
  output logic                  q_par,
`endif
  output logic [WIDTH-1:0]      qn
);

  localparam int PTR_W = ptrWidth(NREQ);

  state_t           r_state, w_stateNext;
  logic [PTR_W-1:0] r_ptr, w_ptrNext;
  logic [PTR_W-1:0] r_winIdx, w_winIdxNext;
  logic [NREQ-1:0]  r_gnt, w_gntNext;
  logic [NREQ-1:0]  r_ack, w_ackNext;
  logic [WIDTH-1:0] r_mask, w_maskNext;
  logic [WIDTH-1:0] r_q, w_qNext;

  logic [NREQ-1:0]  w_win;
  logic [PTR_W-1:0] w_pickIdx;
  logic             w_winReq;
  logic [WIDTH-1:0] w_winMask;

  rr_pick #(
    .NREQ (NREQ),
    .PTR_W(PTR_W)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_win   (w_win),
    .o_winIdx(w_pickIdx)
  );

  always_comb begin
    w_winReq  = 1'b0;
    w_winMask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_winIdx == PTR_W'(i)) begin
        w_winReq  = req[i];
        w_winMask = tmask[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_ptrNext    = r_ptr;
    w_winIdxNext = r_winIdx;
    w_gntNext    = r_gnt;
    w_ackNext    = '0;
    w_maskNext   = r_mask;
    w_qNext      = r_q;
    case (r_state)
      IDLE: begin
        w_gntNext = '0;
        if (|req) begin
          w_gntNext    = w_win;
          w_winIdxNext = w_pickIdx;
          w_stateNext  = GRANT;
        end
      end
      GRANT: begin
        // A requester that withdraws before capture forfeits without moving ptr.
        if (w_winReq) begin
          w_maskNext  = w_winMask;
          w_stateNext = APPLY;
        end else begin
          w_gntNext   = '0;
          w_stateNext = IDLE;
        end
      end
      APPLY: begin
        w_qNext     = r_q ^ r_mask;
        w_ackNext   = r_gnt;
        w_stateNext = ACK;
      end
      ACK: begin
        w_gntNext   = '0;
        w_ptrNext   = (r_winIdx == PTR_W'(NREQ - 1)) ? '0 : r_winIdx + PTR_W'(1);
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
    // Clear overrides any toggle landing on the same edge.
    if (clr) w_qNext = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_winIdx <= '0;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_mask   <= '0;
      r_q      <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_ptr    <= w_ptrNext;
      r_winIdx <= w_winIdxNext;
      r_gnt    <= w_gntNext;
      r_ack    <= w_ackNext;
      r_mask   <= w_maskNext;
      r_q      <= w_qNext;
    end
  end

`ifdef T_BANK_PARITY_EN
  logic r_qPar;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_qPar <= 1'b0;
    else     r_qPar <= ^w_qNext;
  end

  assign q_par = r_qPar;
`endif

  assign gnt  = r_gnt;
  assign ack  = r_ack;
  assign busy = (r_state != IDLE);
  assign q    = r_q;
  assign qn   = ~r_q;

endmodule
